// File: rtl/pid_sched_if.sv
// pid_sched_if: host, measurement, pid and control-output signals of pid_sched.
// PID_MEAS_TMO_EN adds the sticky meas_timeout flag.
interface pid_sched_if #(
  parameter int D_WIDTH   = 16,
  parameter int DIV_WIDTH = 16
);
  logic                 enable;
  logic [DIV_WIDTH-1:0] sample_div;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_addr;
  logic [D_WIDTH-1:0]   cfg_data;
  logic                 meas_valid;
  logic                 meas_ready;
  logic [D_WIDTH-1:0]   meas_data;
  logic [D_WIDTH-1:0]   target_in;
  logic                 pid_we_n;
  logic [D_WIDTH-1:0]   pid_addr;
  logic [D_WIDTH-1:0]   pid_data;
  logic [D_WIDTH-1:0]   pid_target;
  logic [D_WIDTH-1:0]   pid_meas;
  logic [D_WIDTH-1:0]   pid_out;
  logic                 ctrl_valid;
  logic [D_WIDTH-1:0]   ctrl_data;
  logic                 overrun;
  logic                 overrun_clr;
`ifdef PID_MEAS_TMO_EN
  logic                 meas_timeout;
`endif
  modport master (
    output enable, sample_div, cfg_valid, cfg_addr, cfg_data, meas_valid, meas_data,
           target_in, pid_out, overrun_clr,
    input  cfg_ready, meas_ready, pid_we_n, pid_addr, pid_data, pid_target, pid_meas,
           ctrl_valid, ctrl_data, overrun
`ifdef PID_MEAS_TMO_EN
         , meas_timeout
`endif
  );
  modport slave (
    input  enable, sample_div, cfg_valid, cfg_addr, cfg_data, meas_valid, meas_data,
           target_in, pid_out, overrun_clr,
    output cfg_ready, meas_ready, pid_we_n, pid_addr, pid_data, pid_target, pid_meas,
           ctrl_valid, ctrl_data, overrun
`ifdef PID_MEAS_TMO_EN
         , meas_timeout
`endif
  );
endinterface

// File: rtl/pid_sched.sv
// pid_sched: sample-rate scheduler and gain-update sequencer in front of the pid datapath.
// Optional PID_MEAS_TMO_EN: measurement timeout after TMO_CYCLES clocks in WAIT_MEAS.
module pid_sched #(
  parameter int D_WIDTH   = 16,
  parameter int DIV_WIDTH = 16
`ifdef PID_MEAS_TMO_EN
, parameter int TMO_CYCLES = 1000
`endif
) (
  input logic       clock,
  input logic       reset,
  pid_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_MEAS, SETTLE, CAPTURE, CFG_WR} state_t;
  state_t                      state;
  logic [DIV_WIDTH-1:0]        cnt;
  logic                        tick;
  logic [3:0][D_WIDTH-1:0]     shadow;
  logic [3:0]                  pending;
  logic [1:0]                  sel;
`ifdef PID_MEAS_TMO_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0]               tmo;
`endif
  assign tick = bus.enable && cnt == bus.sample_div;
  assign bus.cfg_ready = 1'b1;
  assign bus.meas_ready = state == WAIT_MEAS;
  always_comb sel = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!bus.enable || tick) ? '0 : cnt + 1'b1;
  // An intake on the commit cycle re-arms the pending bit, so the new value is committed later.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      shadow  <= '0;
      pending <= '0;
    end else begin
      if (state == CFG_WR) pending[bus.pid_addr[1:0]] <= 1'b0;
      if (bus.cfg_valid) begin
        shadow[bus.cfg_addr]  <= bus.cfg_data;
        pending[bus.cfg_addr] <= 1'b1;
      end
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state          <= IDLE;
      bus.pid_we_n   <= 1'b1;
      bus.pid_addr   <= '0;
      bus.pid_data   <= '0;
      bus.pid_target <= '0;
      bus.pid_meas   <= '0;
      bus.ctrl_data  <= '0;
      bus.ctrl_valid <= 1'b0;
      bus.overrun    <= 1'b0;
`ifdef PID_MEAS_TMO_EN
      tmo              <= '0;
      bus.meas_timeout <= 1'b0;
`endif
    end else begin
      bus.pid_we_n   <= 1'b1;
      bus.ctrl_valid <= 1'b0;
      bus.overrun    <= (tick && state != IDLE) ? 1'b1 : bus.overrun_clr ? 1'b0 : bus.overrun;
`ifdef PID_MEAS_TMO_EN
      if (bus.overrun_clr) bus.meas_timeout <= 1'b0;
`endif
      case (state)
        IDLE:
          if (tick) begin
            state <= WAIT_MEAS;
`ifdef PID_MEAS_TMO_EN
            tmo <= '0;
`endif
          end else if (|pending) begin
            state        <= CFG_WR;
            bus.pid_we_n <= 1'b0;
            bus.pid_addr <= D_WIDTH'(sel);
            // Forward a same-cycle rewrite so the strobe never carries stale data.
            bus.pid_data <= (bus.cfg_valid && bus.cfg_addr == sel) ? bus.cfg_data : shadow[sel];
          end
        WAIT_MEAS:
          if (bus.meas_valid) begin
            bus.pid_meas   <= bus.meas_data;
            bus.pid_target <= bus.target_in;
            state          <= SETTLE;
          end
`ifdef PID_MEAS_TMO_EN
          else if (tmo == TW'(TMO_CYCLES - 1)) begin
            state            <= IDLE;
            bus.meas_timeout <= 1'b1;
          end else tmo <= tmo + 1'b1;
`endif
        SETTLE: state <= CAPTURE;
        CAPTURE: begin
          bus.ctrl_data  <= bus.pid_out;
          bus.ctrl_valid <= 1'b1;
          state          <= IDLE;
        end
        CFG_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pid_sched.sv
// tb_pid_sched: randomized and directed checks of pid_sched against a queue-based sample/gain model.
module tb_pid_sched;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc[$], cv_cyc[$], wr_cyc[$];
  logic [15:0] acc_val[$], cv_val[$], wr_addr[$], wr_data[$];
  pid_sched_if #(.D_WIDTH(16), .DIV_WIDTH(16)) bus();
`ifdef PID_MEAS_TMO_EN
  pid_sched #(.D_WIDTH(16), .DIV_WIDTH(16), .TMO_CYCLES(5)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
`else
  pid_sched #(.D_WIDTH(16), .DIV_WIDTH(16)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
`endif
  assign bus.pid_out = bus.pid_target - bus.pid_meas;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (bus.meas_ready && bus.meas_valid) begin
      acc_cyc.push_back(cyc);
      acc_val.push_back(bus.target_in - bus.meas_data);
    end
    if (bus.ctrl_valid) begin
      cv_cyc.push_back(cyc);
      cv_val.push_back(bus.ctrl_data);
    end
    if (!bus.pid_we_n) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.pid_addr);
      wr_data.push_back(bus.pid_data);
    end
  end
  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic clear_q();
    acc_cyc.delete(); acc_val.delete(); cv_cyc.delete(); cv_val.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.sample_div = '0; bus.cfg_valid = 1'b0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.meas_valid = 1'b0; bus.meas_data = '0; bus.target_in = '0;
    bus.overrun_clr = 1'b0;
    cyc_wait(2);
    reset = 1'b0;
    cyc_wait(1);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!bus.meas_ready && n < 100) begin
      cyc_wait(1);
      n++;
    end
    checks++;
    if (bus.meas_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: meas_ready=%b after %0d cycles, required 1", bus.meas_ready, n);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.pid_we_n, bus.ctrl_valid, bus.overrun, bus.meas_ready, bus.cfg_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_flags: we_n/cv/ovr/mrdy/crdy=%b, required 10001",
               {bus.pid_we_n, bus.ctrl_valid, bus.overrun, bus.meas_ready, bus.cfg_ready});
    end
    checks++;
    if ({bus.pid_addr, bus.pid_data, bus.pid_target, bus.pid_meas, bus.ctrl_data} !== 80'd0) begin
      errors++;
      $display("FAIL reset_data: addr/data/target/meas/ctrl=%h, required 0",
               {bus.pid_addr, bus.pid_data, bus.pid_target, bus.pid_meas, bus.ctrl_data});
    end
    bus.sample_div = 16'd0;
    cyc_wait(5);
    checks++;
    if (bus.meas_ready !== 1'b0) begin
      errors++;
      $display("FAIL disabled_no_tick: meas_ready=%b, required 0", bus.meas_ready);
    end
  endtask
  task automatic test_tick();
    int c0;
    do_reset();
    clear_q();
    bus.sample_div = 16'd9;
    bus.meas_valid = 1'b1;
    bus.enable = 1'b1;
    c0 = cyc;
    repeat (45) begin
      bus.meas_data = 16'($urandom);
      bus.target_in = 16'($urandom);
      cyc_wait(1);
    end
    bus.enable = 1'b0;
    cyc_wait(6);
    checks++;
    if (acc_cyc.size() != 4 || cv_cyc.size() != 4) begin
      errors++;
      $display("FAIL tick_count: accepts=%0d ctrl=%0d, required 4 and 4", acc_cyc.size(), cv_cyc.size());
    end else begin
      checks++;
      if (acc_cyc[0] - c0 != 10) begin
        errors++;
        $display("FAIL tick_first: accept after %0d clk, required 10", acc_cyc[0] - c0);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cv_cyc[i] - acc_cyc[i] != 3 || cv_val[i] !== acc_val[i] ||
            (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 10)) begin
          errors++;
          $display("FAIL tick_sample%0d: latency=%0d data=%h period=%0d, required 3 %h 10", i,
                   cv_cyc[i] - acc_cyc[i], cv_val[i], i > 0 ? acc_cyc[i] - acc_cyc[i-1] : 10, acc_val[i]);
        end
      end
    end
  endtask
  task automatic test_cfg_order();
    do_reset();
    bus.sample_div = 16'd20;
    bus.enable = 1'b1;
    wait_ready();
    clear_q();
    bus.cfg_valid = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_data = 16'h0100;
    cyc_wait(1);
    bus.cfg_addr = 2'd0; bus.cfg_data = 16'h0200;
    cyc_wait(1);
    bus.cfg_valid = 1'b0;
    bus.enable = 1'b0;
    bus.meas_valid = 1'b1;
    cyc_wait(10);
    checks++;
    if (wr_cyc.size() != 2 || cv_cyc.size() != 1) begin
      errors++;
      $display("FAIL cfg_order_count: writes=%0d ctrl=%0d, required 2 and 1", wr_cyc.size(), cv_cyc.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 16'd0 || wr_data[0] !== 16'h0200 || wr_addr[1] !== 16'd2 || wr_data[1] !== 16'h0100) begin
        errors++;
        $display("FAIL cfg_order: %h=%h then %h=%h, required 0000=0200 then 0002=0100",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
      checks++;
      if (wr_cyc[0] <= cv_cyc[0] || wr_cyc[1] - wr_cyc[0] != 2) begin
        errors++;
        $display("FAIL cfg_spacing: ctrl@%0d wr@%0d,%0d, required writes after ctrl, 2 apart",
                 cv_cyc[0], wr_cyc[0], wr_cyc[1]);
      end
    end
  endtask
  task automatic test_cfg_tick();
    int c0;
    logic [15:0] d;
    d = 16'($urandom);
    do_reset();
    clear_q();
    bus.sample_div = 16'd9;
    bus.meas_valid = 1'b1;
    bus.enable = 1'b1;
    c0 = cyc;
    cyc_wait(9);
    bus.cfg_valid = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = d;
    cyc_wait(1);
    bus.cfg_valid = 1'b0;
    bus.enable = 1'b0;
    cyc_wait(10);
    checks++;
    if (acc_cyc.size() != 1 || cv_cyc.size() != 1 || wr_cyc.size() != 1) begin
      errors++;
      $display("FAIL cfg_tick_count: acc=%0d ctrl=%0d wr=%0d, required 1 1 1",
               acc_cyc.size(), cv_cyc.size(), wr_cyc.size());
    end else begin
      checks++;
      if (acc_cyc[0] - c0 != 10 || wr_cyc[0] != cv_cyc[0] + 1 || wr_addr[0] !== 16'd1 || wr_data[0] !== d) begin
        errors++;
        $display("FAIL cfg_tick: acc@+%0d wr@%0d ctrl@%0d wr %h=%h, required acc@+10 wr=ctrl+1 0001=%h",
                 acc_cyc[0] - c0, wr_cyc[0], cv_cyc[0], wr_addr[0], wr_data[0], d);
      end
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL cfg_tick_overrun: overrun=%b, required 0", bus.overrun);
    end
  endtask
  task automatic test_overrun();
    do_reset();
    bus.sample_div = 16'd9;
    bus.enable = 1'b1;
    cyc_wait(25);
    checks++;
    if (bus.overrun !== 1'b1 || bus.meas_ready !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b meas_ready=%b, required 1 1", bus.overrun, bus.meas_ready);
    end
    bus.enable = 1'b0;
    bus.overrun_clr = 1'b1;
    cyc_wait(1);
    bus.overrun_clr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr: overrun=%b, required 0", bus.overrun);
    end
    bus.sample_div = 16'd0;
    bus.enable = 1'b1;
    bus.overrun_clr = 1'b1;
    cyc_wait(3);
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_beats_clr: overrun=%b, required 1", bus.overrun);
    end
    bus.enable = 1'b0;
    cyc_wait(1);
    bus.overrun_clr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr2: overrun=%b, required 0", bus.overrun);
    end
    bus.meas_valid = 1'b1;
    cyc_wait(6);
  endtask
  task automatic test_reset_mid();
    logic [15:0] m;
    m = 16'($urandom) | 16'h0001;
    do_reset();
    bus.sample_div = 16'd4;
    bus.enable = 1'b1;
    wait_ready();
    bus.meas_data = m;
    bus.target_in = 16'h1234;
    bus.meas_valid = 1'b1;
    cyc_wait(1);
    checks++;
    if (bus.pid_meas !== m || bus.pid_target !== 16'h1234) begin
      errors++;
      $display("FAIL settle_capture: pid_meas=%h pid_target=%h, required %h 1234", bus.pid_meas, bus.pid_target, m);
    end
    clear_q();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.pid_we_n, bus.ctrl_valid, bus.overrun, bus.meas_ready, bus.cfg_ready} !== 5'b10001 ||
        {bus.pid_target, bus.pid_meas, bus.ctrl_data} !== 48'd0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b target/meas/ctrl=%h, required 10001 0",
               {bus.pid_we_n, bus.ctrl_valid, bus.overrun, bus.meas_ready, bus.cfg_ready},
               {bus.pid_target, bus.pid_meas, bus.ctrl_data});
    end
    cyc_wait(2);
    bus.enable = 1'b0;
    reset = 1'b0;
    cyc_wait(6);
    checks++;
    if (cv_cyc.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_no_ctrl: ctrl pulses=%0d, required 0", cv_cyc.size());
    end
  endtask
`ifdef PID_MEAS_TMO_EN
  task automatic test_timeout();
    do_reset();
    clear_q();
    bus.sample_div = 16'd50;
    bus.enable = 1'b1;
    wait_ready();
    bus.enable = 1'b0;
    cyc_wait(4);
    checks++;
    if (bus.meas_ready !== 1'b1 || bus.meas_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: meas_ready=%b meas_timeout=%b, required 1 0", bus.meas_ready, bus.meas_timeout);
    end
    cyc_wait(1);
    checks++;
    if (bus.meas_ready !== 1'b0 || bus.meas_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire: meas_ready=%b meas_timeout=%b, required 0 1", bus.meas_ready, bus.meas_timeout);
    end
    cyc_wait(5);
    checks++;
    if (cv_cyc.size() != 0) begin
      errors++;
      $display("FAIL tmo_no_ctrl: ctrl pulses=%0d, required 0", cv_cyc.size());
    end
  endtask
`endif
  task automatic test_random();
    logic [15:0] gain [4];
    logic [15:0] seen [4];
    for (int i = 0; i < 4; i++) begin
      gain[i] = '0;
      seen[i] = '0;
    end
    do_reset();
    clear_q();
    bus.sample_div = 16'd5;
    repeat (600) begin
      bus.enable = $urandom_range(0, 9) != 0;
      if (!bus.enable) bus.sample_div = 16'($urandom_range(3, 12));
`ifdef PID_MEAS_TMO_EN
      bus.meas_valid = 1'b1;
`else
      bus.meas_valid = $urandom_range(0, 2) != 0;
`endif
      bus.meas_data = 16'($urandom);
      bus.target_in = 16'($urandom);
      bus.cfg_valid = $urandom_range(0, 3) == 0;
      bus.cfg_addr = 2'($urandom);
      bus.cfg_data = 16'($urandom);
      bus.overrun_clr = $urandom_range(0, 7) == 0;
      if (bus.cfg_valid) gain[bus.cfg_addr] = bus.cfg_data;
      cyc_wait(1);
    end
    bus.enable = 1'b0; bus.meas_valid = 1'b1; bus.cfg_valid = 1'b0; bus.overrun_clr = 1'b0;
    cyc_wait(30);
    checks++;
    if (cv_cyc.size() != acc_cyc.size() || acc_cyc.size() == 0) begin
      errors++;
      $display("FAIL rand_count: ctrl=%0d accepts=%0d, required equal and nonzero", cv_cyc.size(), acc_cyc.size());
    end else
      for (int i = 0; i < acc_cyc.size(); i++) begin
        checks++;
        if (cv_cyc[i] - acc_cyc[i] != 3 || cv_val[i] !== acc_val[i]) begin
          errors++;
          $display("FAIL rand_sample%0d: latency=%0d data=%h, required 3 %h",
                   i, cv_cyc[i] - acc_cyc[i], cv_val[i], acc_val[i]);
        end
      end
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] < 16'd4) seen[wr_addr[i][1:0]] = wr_data[i];
      else begin
        checks++;
        errors++;
        $display("FAIL rand_addr: pid_addr=%h, required < 4", wr_addr[i]);
      end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== gain[i]) begin
        errors++;
        $display("FAIL rand_gain%0d: committed=%h, required %h", i, seen[i], gain[i]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_tick();
    test_cfg_order();
    test_cfg_tick();
    test_overrun();
    test_reset_mid();
`ifdef PID_MEAS_TMO_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
